// File: rtl/oclib_pkg.sv
// ---------------------------------------------------------------------------
// oclib_pkg
//
// Shared types and constants for the oclib CSR fabric and its bridges.
//
// Contents:
//   BcSpaceIdAny             - broadcast CSR space id, matched by every leaf
//   DefaultApbTimeoutCycles  - default ACCESS-phase limit for APB bridges
//   csr_32_s / csr_32_fb_s   - parallel CSR request / response
//   apb_s / apb_fb_s         - APB requester outputs / completer feedback
//   csr_space_match()        - space filter used by CSR leaves
// ---------------------------------------------------------------------------
package oclib_pkg;

    localparam logic [3:0] BcSpaceIdAny            = 4'hf;
    localparam integer     DefaultApbTimeoutCycles = 1024;

    // CSR request. read/write are levels held together with address/wdata
    // until the response pulse.
    typedef struct packed {
        logic        read;
        logic        write;
        logic [3:0]  space;
        logic [31:0] address;
        logic [31:0] wdata;
    } csr_32_s;

    // CSR response. ready is a single-cycle pulse; error/rdata qualify it.
    typedef struct packed {
        logic        ready;
        logic        error;
        logic [1:0]  reserved;
        logic [31:0] rdata;
    } csr_32_fb_s;

    // APB requester signals.
    typedef struct packed {
        logic        select;
        logic        enable;
        logic        write;
        logic [31:0] address;
        logic [31:0] wdata;
    } apb_s;

    // APB completer feedback.
    typedef struct packed {
        logic        ready;
        logic        error;
        logic [31:0] rdata;
    } apb_fb_s;

    // True when a request addressed to req_space targets a leaf at my_space.
    function automatic logic csr_space_match(input logic [3:0] req_space,
                                             input logic [3:0] my_space);
        return (req_space == my_space) || (req_space == BcSpaceIdAny);
    endfunction

endpackage

// File: rtl/oclib_synchronizer.sv
// ---------------------------------------------------------------------------
// oclib_synchronizer
//
// Multi-flop synchroniser with asynchronous clear. Used both for CDC of
// quasi-static signals and as a reset synchroniser (d tied high, q is a
// reset that asserts asynchronously and releases after SyncCycles clocks).
//
// Ports:
//   clock   in  1      destination clock
//   resetN  in  1      asynchronous active-low clear to ResetValue
//   d       in  Width  signal to synchronise
//   q       out Width  synchronised signal
// ---------------------------------------------------------------------------
module oclib_synchronizer #(
    parameter int               Width      = 1,
    parameter int               SyncCycles = 2,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] stages [SyncCycles];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < SyncCycles; i++) begin
                stages[i] <= ResetValue;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SyncCycles; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SyncCycles-1];

endmodule

// File: rtl/oclib_csr_to_apb.sv
// ---------------------------------------------------------------------------
// oclib_csr_to_apb
//
// Bridge from the parallel CSR protocol to an APB requester. Each accepted
// CSR request becomes one two-phase APB transfer (SETUP then ACCESS) bounded
// by a timeout, and is answered with a single-cycle CSR response.
//
// Handshake semantics:
//   csr.read / csr.write are request levels; the bridge samples them only in
//   IDLE. csrFb.ready is a one-cycle completion pulse with error/rdata valid
//   alongside it. After the pulse the bridge waits for both request levels to
//   drop before it will accept again, so a held request is never re-issued.
//   On the APB side select/enable follow the standard SETUP/ACCESS sequence;
//   apbFb.ready is sampled only while enable is high.
//
// Parameters:
//   Space          CSR space this leaf answers (plus BcSpaceIdAny)
//   TimeoutCycles  ACCESS cycles before abort, legal range 2..65535
//
// Ports:
//   clock      in   1            sole clock
//   resetN     in   1            async assert, synchronised release
//   csr        in   csr_32_s     CSR request
//   csrFb      out  csr_32_fb_s  CSR response (registered)
//   apb        out  apb_s        APB request (registered)
//   apbFb      in   apb_fb_s     APB completion
//   dbg_state  out  3            current FSM state encoding
// ---------------------------------------------------------------------------
module oclib_csr_to_apb
    import oclib_pkg::*;
#(
    parameter logic [3:0] Space         = 4'h0,
    parameter int         TimeoutCycles = DefaultApbTimeoutCycles
) (
    input  logic       clock,
    input  logic       resetN,
    input  csr_32_s    csr,
    output csr_32_fb_s csrFb,
    output apb_s       apb,
    input  apb_fb_s    apbFb,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSetup  = 3'd1,
        StAccess = 3'd2,
        StResp   = 3'd3,
        StDrain  = 3'd4
    } state_e;

    // Count value at which the last permitted ACCESS cycle is running.
    localparam logic [15:0] TimeoutLimit = 16'(TimeoutCycles - 1);

    state_e      state;
    logic [15:0] count;
    logic        rst_n_sync;
    logic        space_hit;
    logic        req_single;
    logic        req_both;

    // Reset asserts immediately (the synchroniser flops clear asynchronously)
    // and releases two clocks after resetN rises.
    oclib_synchronizer #(
        .Width      (1),
        .SyncCycles (2),
        .ResetValue (1'b0)
    ) u_reset_sync (
        .clock  (clock),
        .resetN (resetN),
        .d      (1'b1),
        .q      (rst_n_sync)
    );

    assign space_hit  = csr_space_match(csr.space, Space);
    assign req_single = csr.read ^ csr.write;
    assign req_both   = csr.read & csr.write;

    always_ff @(posedge clock or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state <= StIdle;
            count <= '0;
            csrFb <= '0;
            apb   <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (space_hit && req_single) begin
                        // Capture the request once; later changes on csr are
                        // ignored until the transfer completes.
                        apb.select  <= 1'b1;
                        apb.enable  <= 1'b0;
                        apb.address <= csr.address;
                        apb.wdata   <= csr.wdata;
                        apb.write   <= csr.write;
                        state       <= StSetup;
                    end else if (space_hit && req_both) begin
                        // Simultaneous read and write is answered with an
                        // error without touching the APB side.
                        csrFb.ready <= 1'b1;
                        csrFb.error <= 1'b1;
                        csrFb.rdata <= '0;
                        state       <= StResp;
                    end
                end

                StSetup: begin
                    apb.enable <= 1'b1;
                    count      <= '0;
                    state      <= StAccess;
                end

                StAccess: begin
                    // ready is checked first so a completion in the final
                    // permitted cycle is not reported as a timeout.
                    if (apbFb.ready) begin
                        apb.select  <= 1'b0;
                        apb.enable  <= 1'b0;
                        csrFb.ready <= 1'b1;
                        csrFb.error <= apbFb.error;
                        csrFb.rdata <= apb.write ? 32'h0 : apbFb.rdata;
                        state       <= StResp;
                    end else if (count == TimeoutLimit) begin
                        apb.select  <= 1'b0;
                        apb.enable  <= 1'b0;
                        csrFb.ready <= 1'b1;
                        csrFb.error <= 1'b1;
                        csrFb.rdata <= '0;
                        state       <= StResp;
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                StResp: begin
                    csrFb <= '0;
                    state <= StDrain;
                end

                StDrain: begin
                    if (!csr.read && !csr.write) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_oclib_csr_to_apb.sv
// ---------------------------------------------------------------------------
// tb_oclib_csr_to_apb
//
// Directed bench for the CSR-to-APB bridge. The driver issues CSR requests
// and pushes the expected {cycle, error, rdata} into exp_q; a monitor on the
// falling edge pops and compares whenever csrFb.ready is seen, and also
// tracks APB SETUP/ACCESS cycles and field stability. A small peripheral
// model answers after a programmable number of wait states.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oclib_csr_to_apb;
    import oclib_pkg::*;

    localparam logic [3:0] MySpace = 4'h3;
    localparam int         Tmo     = 8;

    // ---------------- clock / reset ----------------
    logic       clock = 1'b0;
    logic       resetN;
    csr_32_s    csr;
    csr_32_fb_s csrFb;
    apb_s       apb;
    apb_fb_s    apbFb;
    logic [2:0] dbg_state;

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    oclib_csr_to_apb #(
        .Space         (MySpace),
        .TimeoutCycles (Tmo)
    ) dut (
        .clock     (clock),
        .resetN    (resetN),
        .csr       (csr),
        .csrFb     (csrFb),
        .apb       (apb),
        .apbFb     (apbFb),
        .dbg_state (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- peripheral model ----------------
    int          ws      = 0;
    bit          never   = 1'b0;
    logic [31:0] p_rdata = 32'h0;
    logic        p_err   = 1'b0;
    int          acc_n   = 0;

    // Ready is raised in the (ws+1)-th ACCESS cycle unless 'never' is set.
    always @(negedge clock) begin
        if (apb.select && apb.enable) begin
            apbFb.ready = !never && (acc_n == ws);
            acc_n++;
        end else begin
            acc_n       = 0;
            apbFb.ready = 1'b0;
        end
        apbFb.rdata = p_rdata;
        apbFb.error = p_err;
    end

    // ---------------- scoreboard / monitor ----------------
    logic [64:0] exp_q[$];        // {cycle[31:0], error, rdata[31:0]}
    logic [64:0] exp_apb = '0;    // {address, wdata, write} of the current transfer
    int          setup_cnt  = 0;
    int          access_cnt = 0;
    int          snap_setup  = 0;
    int          snap_access = 0;

    always @(negedge clock) begin : monitor
        logic [64:0] e;
        if (csrFb.ready) begin
            check("resp_expected", 96'(exp_q.size() != 0), 96'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("resp_cycle", 96'(cyc), 96'(e[64:33]));
                check("resp_error", 96'(csrFb.error), 96'(e[32]));
                check("resp_rdata", 96'(csrFb.rdata), 96'(e[31:0]));
                check("resp_reserved", 96'(csrFb.reserved), 96'd0);
            end
        end
        if (apb.select) begin
            if (!apb.enable) setup_cnt++;
            else access_cnt++;
            check("apb_fields", 96'({apb.address, apb.wdata, apb.write}), 96'(exp_apb));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic snap();
        snap_setup  = setup_cnt;
        snap_access = access_cnt;
    endtask

    task automatic check_counts(input string name, input int exp_setup, input int exp_access);
        check({name, "_setups"},   96'(setup_cnt - snap_setup),   96'(exp_setup));
        check({name, "_accesses"}, 96'(access_cnt - snap_access), 96'(exp_access));
    endtask

    // Issue one request; lat is the expected response cycle relative to the
    // cycle in which the request is first sampled. hold = extra cycles the
    // request stays high after the response (or in total if none expected).
    task automatic req(input logic rd, input logic wr, input logic [3:0] sp,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input bit expect_resp, input int lat,
                       input logic err, input logic [31:0] rdata, input int hold);
        int waited;
        @(posedge clock); #1;
        exp_apb     = {addr, wd, wr};
        csr.read    = rd;
        csr.write   = wr;
        csr.space   = sp;
        csr.address = addr;
        csr.wdata   = wd;
        if (expect_resp) begin
            exp_q.push_back({32'(cyc + lat), err, rdata});
            waited = 0;
            do begin
                @(negedge clock);
                waited++;
            end while (!csrFb.ready && waited < 40);
            check("resp_seen", 96'(csrFb.ready), 96'd1);
        end
        repeat (hold) @(negedge clock);
        @(posedge clock); #1;
        csr.read  = 1'b0;
        csr.write = 1'b0;
    endtask

    task automatic settle(input string name);
        repeat (4) @(posedge clock);
        check({name, "_queue_empty"}, 96'(exp_q.size()), 96'd0);
        exp_q.delete();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        resetN = 1'b0;
        csr    = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_csrfb", 96'(csrFb), 96'd0);
        check("reset_apb",   96'(apb),   96'd0);
        check("reset_state", 96'(dbg_state), 96'd0);
        resetN = 1'b1;
        repeat (4) @(posedge clock);

        // Zero-wait read.
        ws = 0; never = 1'b0; p_err = 1'b0; p_rdata = 32'hCAFEF00D; snap();
        req(1'b1, 1'b0, MySpace, 32'h10, 32'h0, 1'b1, 3, 1'b0, 32'hCAFEF00D, 0);
        settle("zero_wait");
        check_counts("zero_wait", 1, 1);

        // Write with 3 wait states; write returns rdata 0.
        ws = 3; p_rdata = 32'hDEADBEEF; snap();
        req(1'b0, 1'b1, MySpace, 32'h20, 32'h12345678, 1'b1, 6, 1'b0, 32'h0, 0);
        settle("write_ws3");
        check_counts("write_ws3", 1, 4);

        // Timeout: peripheral never ready.
        never = 1'b1; snap();
        req(1'b1, 1'b0, MySpace, 32'h30, 32'h0, 1'b1, 2 + Tmo, 1'b1, 32'h0, 0);
        settle("timeout");
        check_counts("timeout", 1, Tmo);

        // Ready in the last permitted ACCESS cycle wins over timeout.
        never = 1'b0; ws = Tmo - 1; p_rdata = 32'h0BADCAFE; snap();
        req(1'b1, 1'b0, MySpace, 32'h34, 32'h0, 1'b1, 2 + Tmo, 1'b0, 32'h0BADCAFE, 0);
        settle("timeout_race");
        check_counts("timeout_race", 1, Tmo);

        // Peripheral error on a read with one wait state.
        ws = 1; p_err = 1'b1; p_rdata = 32'h55AA55AA; snap();
        req(1'b1, 1'b0, MySpace, 32'h40, 32'h0, 1'b1, 4, 1'b1, 32'h55AA55AA, 0);
        settle("periph_error");
        check_counts("periph_error", 1, 2);
        p_err = 1'b0;

        // Illegal read+write: immediate error, no APB activity.
        snap();
        req(1'b1, 1'b1, MySpace, 32'h50, 32'h11, 1'b1, 1, 1'b1, 32'h0, 0);
        settle("illegal");
        check_counts("illegal", 0, 0);

        // Space mismatch: ignored entirely.
        snap();
        req(1'b1, 1'b0, 4'h5, 32'h60, 32'h0, 1'b0, 0, 1'b0, 32'h0, 10);
        settle("mismatch");
        check_counts("mismatch", 0, 0);

        // Broadcast space is accepted.
        ws = 0; p_rdata = 32'h00C0FFEE; snap();
        req(1'b1, 1'b0, BcSpaceIdAny, 32'h70, 32'h0, 1'b1, 3, 1'b0, 32'h00C0FFEE, 0);
        settle("broadcast");
        check_counts("broadcast", 1, 1);

        // Held request: read stays high 10 cycles past the response.
        p_rdata = 32'h13579BDF; snap();
        req(1'b1, 1'b0, MySpace, 32'h80, 32'h0, 1'b1, 3, 1'b0, 32'h13579BDF, 10);
        settle("held");
        check_counts("held", 1, 1);

        // Reset in the middle of ACCESS.
        never = 1'b1; snap();
        @(posedge clock); #1;
        exp_apb     = {32'h90, 32'h0, 1'b0};
        csr.read    = 1'b1;
        csr.write   = 1'b0;
        csr.space   = MySpace;
        csr.address = 32'h90;
        csr.wdata   = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("midreset_in_access", 96'(dbg_state), 96'd2);
        resetN = 1'b0;
        #1;
        check("midreset_csrfb", 96'(csrFb), 96'd0);
        check("midreset_apb",   96'(apb),   96'd0);
        check("midreset_state", 96'(dbg_state), 96'd0);
        csr.read = 1'b0;
        @(posedge clock); #1;
        resetN = 1'b1;
        repeat (4) @(posedge clock);
        never = 1'b0; ws = 0; p_rdata = 32'hA5A5F00F;
        req(1'b1, 1'b0, MySpace, 32'hA0, 32'h0, 1'b1, 3, 1'b0, 32'hA5A5F00F, 0);
        settle("after_reset");
        check_counts("after_reset", 2, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
